// File: rtl/prio_pkg.sv
// Shared types and constants for the 9-line active-low priority arbiter.
// The code convention: highest index wins, code_n = ~(index+1), idle code all ones.
package prio_pkg;

  localparam int         N_REQ     = 9;
  localparam logic [3:0] CODE_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
    return ~(idx + 4'd1);
  endfunction

endpackage

// File: rtl/prio_req_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The master modport is the requester side; the arbiter takes the slave modport.
interface prio_req_arbiter_if
  import prio_pkg::*;
#(
  parameter int CNT_W = 4
);
  logic [N_REQ-1:0] req_n;
  logic [N_REQ-1:0] mask;
  logic             done;
  logic [N_REQ-1:0] grant_n;
  logic [3:0]       code_n;
  logic             grant_vld;
  logic             timeout;
  logic [CNT_W-1:0] busy_cnt;

  modport master (
    output req_n, mask, done,
    input  grant_n, code_n, grant_vld, timeout, busy_cnt
  );

  modport slave (
    input  req_n, mask, done,
    output grant_n, code_n, grant_vld, timeout, busy_cnt
  );
endinterface

// File: rtl/prio_sel9.sv
// Combinational highest-index selector over the 9 request lines.
// Produces a valid flag, the winning index and its one-hot position.
module prio_sel9
  import prio_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic             valid,
  output logic [3:0]       idx,
  output logic [N_REQ-1:0] onehot
);

  // Scanning upward lets the last set bit (the highest index) win.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) begin
        valid     = 1'b1;
        idx       = 4'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_req_arbiter.sv
// Sequential priority arbiter: one grant held until done, request drop or hold timeout.
// A timed-out requester stays locked out until it releases its request.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no owner; grant the highest eligible requester next edge
//   ST_GRANT   | owner holds the resource; busy_cnt counts held cycles
//   ST_RELEASE | one-cycle gap between owners; timeout pulses here if forced
module prio_req_arbiter
  import prio_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  prio_req_arbiter_if.slave bus
);

  state_t           state, state_nxt;
  logic [3:0]       owner, owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0] lockout, lock_nxt;
  logic [N_REQ-1:0] grant_n_q, grant_n_nxt;
  logic [3:0]       code_n_q, code_n_nxt;
  logic             vld_q, vld_nxt;
  logic             timeout_q, timeout_nxt;

  logic [N_REQ-1:0] eligible;
  logic             sel_vld;
  logic [3:0]       sel_idx;
  logic [N_REQ-1:0] sel_onehot;

  assign eligible = ~bus.req_n & ~bus.mask & ~lockout;

  prio_sel9 u_sel (
    .vec    (eligible),
    .valid  (sel_vld),
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= '0;
      cnt       <= '0;
      lockout   <= '0;
      grant_n_q <= '1;
      code_n_q  <= CODE_IDLE;
      vld_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      cnt       <= cnt_nxt;
      lockout   <= lock_nxt;
      grant_n_q <= grant_n_nxt;
      code_n_q  <= code_n_nxt;
      vld_q     <= vld_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    cnt_nxt     = cnt;
    grant_n_nxt = grant_n_q;
    code_n_nxt  = code_n_q;
    vld_nxt     = vld_q;
    timeout_nxt = 1'b0;
    // A released request always clears its lockout, whatever the state.
    lock_nxt    = lockout & ~bus.req_n;

    case (state)
      ST_IDLE: begin
        if (sel_vld) begin
          state_nxt   = ST_GRANT;
          owner_nxt   = sel_idx;
          cnt_nxt     = CNT_W'(1);
          grant_n_nxt = ~sel_onehot;
          code_n_nxt  = idx_to_code(sel_idx);
          vld_nxt     = 1'b1;
        end
      end

      ST_GRANT: begin
        if (bus.done || bus.req_n[owner] || (cnt == CNT_W'(HOLD_MAX))) begin
          state_nxt   = ST_RELEASE;
          cnt_nxt     = '0;
          grant_n_nxt = '1;
          code_n_nxt  = CODE_IDLE;
          vld_nxt     = 1'b0;
          // Only a pure hold-limit release is a timeout; done takes precedence.
          if (!bus.done && !bus.req_n[owner]) begin
            timeout_nxt     = 1'b1;
            lock_nxt[owner] = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        state_nxt   = ST_IDLE;
        cnt_nxt     = '0;
        grant_n_nxt = '1;
        code_n_nxt  = CODE_IDLE;
        vld_nxt     = 1'b0;
      end

      default: begin
        state_nxt   = ST_IDLE;
        cnt_nxt     = '0;
        grant_n_nxt = '1;
        code_n_nxt  = CODE_IDLE;
        vld_nxt     = 1'b0;
      end
    endcase
  end

  assign bus.grant_n   = grant_n_q;
  assign bus.code_n    = code_n_q;
  assign bus.grant_vld = vld_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy_cnt  = cnt;

endmodule

// File: doc/prio_req_arbiter.md
Name: prio_req_arbiter

Overview:
- Sequential priority arbiter that shares one downstream resource among 9 active-low requesters.
- Uses the team's 9-line active-low priority-encoding convention: highest index wins, code_n = ~(index+1), and idle code is 4'b1111.
- Holds a grant until the owner signals done, drops its request, or exceeds a hold timeout.
- A requester that times out is locked out until it releases its request.
- Sits between request sources (interrupt/DMA-style clients) and the shared datapath.

Parameters:
- HOLD_MAX, 15, maximum number of GRANT cycles before a forced release; legal range 1..15.
- CNT_W, 4, hold-counter width; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_n  input  9  active-low requests; bit 8 highest priority, bit 0 lowest.
- mask  input  9  1 = requester ignored for new arbitration; does not revoke a live grant.
- done  input  1  owner finished; sampled only in GRANT.
- grant_n  output  9  one-hot active-low grant; all ones when no grant.
- code_n  output  4  active-low encoded owner, ~(index+1); 4'b1111 when idle.
- grant_vld  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse on a forced release.
- busy_cnt  output  CNT_W  cycles spent in the current GRANT; 0 outside GRANT.

Behaviour:
- All outputs and state are registered.
- Reset (rst_n=0 at a clk edge): state=IDLE, grant_n=9'h1FF, code_n=4'b1111, grant_vld=0, timeout=0, busy_cnt=0, lockout=0. Reset mid-GRANT drops the grant in the same edge.
- eligible[k] = ~req_n[k] & ~mask[k] & ~lockout[k].
- State IDLE: if any eligible bit is set, select k = highest set index. On the next edge go to GRANT with grant_n[k]=0, code_n=~(k+1), grant_vld=1, busy_cnt=1, and register owner=k. Latency: 1 clk from the sampled request to the visible grant. If nothing is eligible, stay in IDLE.
- State GRANT, evaluated each edge in this priority order:
  - (a) done=1 -> RELEASE, no timeout.
  - (b) req_n[owner]=1 (request withdrawn) -> RELEASE, no timeout.
  - (c) busy_cnt==HOLD_MAX -> RELEASE, timeout=1 for one cycle, lockout[owner]=1.
  - (d) otherwise busy_cnt+1 and hold the grant.
  - done and the timeout condition in the same cycle: done wins, no timeout.
  - busy_cnt never wraps.
- GRANT preemption: none. Higher-priority requests wait; mask changes do not affect the owner.
- State RELEASE: exactly one cycle, then unconditionally IDLE. Outputs in RELEASE: grant_n=9'h1FF, code_n=4'b1111, grant_vld=0, busy_cnt=0; timeout high only if entered via (c). Guarantees a 1-cycle gap between owners.
- Lockout: lockout[k] clears at any edge where req_n[k]=1, in every state. A locked requester is never selected.
- Back-to-back: a requester holding req_n low through RELEASE can be re-granted in the next IDLE cycle. Minimum re-grant period is 3 clks (GRANT, RELEASE, IDLE).
- req_n all ones in IDLE: outputs stay idle indefinitely.
- Invariant: at most one grant_n bit is low; code_n, grant_n, and grant_vld are always mutually consistent.

Decomposition:
- Shared package prio_pkg:
  - state encoding localparams ST_IDLE, ST_GRANT, ST_RELEASE (2 bits).
  - N_REQ=9.
  - CODE_IDLE=4'b1111.
  - Function/localparam convention for index to active-low code.
- One natural sub-module: prio_sel9, a combinational 9-bit highest-index selector producing a valid flag, a 4-bit index, and a one-hot mask.
- The FSM, hold counter, and lockout register live in the top module.

Test Plan:
1. Reset, then req_n=9'h1FF for 10 clks -> grant_n=9'h1FF, code_n=4'b1111, grant_vld=0 throughout.
2. Reset mid-operation: rst_n=0 while in GRANT -> at that edge grant_n=9'h1FF, code_n=4'b1111, grant_vld=0, busy_cnt=0, lockout cleared; IDLE after rst_n returns high.
3. Priority and latency: req_n=9'b1_0111_1110 (bits 7 and 0 low) -> 1 clk later grant_n=9'b1_0111_1111, code_n=4'b0111; done pulse -> RELEASE cycle with code_n=4'b1111 -> bit 0 granted with code_n=4'b1110 one IDLE cycle later.
4. Mask and no preemption: bit 2 granted, then assert req_n[8]=0 -> grant stays on bit 2 until done; mask[8]=1 at the IDLE cycle -> bit 8 is skipped and the next eligible index is granted.
5. Timeout with HOLD_MAX=15: bit 5 holds its request with no done -> busy_cnt climbs 1..15, timeout pulses in the RELEASE cycle, bit 5 is not re-granted while req_n[5]=0; raise req_n[5] for 1 clk and lower it again -> bit 5 is granted again.
6. Corner cases:
   - done=1 in the same cycle busy_cnt==15 -> timeout stays 0 and no lockout.
   - Owner raises req_n during GRANT -> RELEASE next edge with timeout=0.
